// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse key front-end.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int   MAX_SYMS = 4;
    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;
    localparam int   LEN_W    = 3;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output only
// follows the input after DEBOUNCE_CYC consecutive disagreeing samples.
module morse_debounce #(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int CNT_W        = 16
) (
    input  logic CLKin,
    input  logic RSTn,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Any agreeing sample restarts the count, so bounces never accumulate.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/morse_keyer.sv
// Morse key front-end: debounced key, dot/dash classification by press
// length, and end-of-letter detection by release length.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int DASH_CYC     = 3000,
    parameter int GAP_CYC      = 6000,
    parameter int CNT_W        = 16
) (
    input  logic             CLKin,
    input  logic             RSTn,
    input  logic             key_in,
    output logic             sym_valid,
    output logic             sym_dash,
    output logic             letter_end,
    output logic [LEN_W-1:0] letter_len,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] DASH_T = CNT_W'(DASH_CYC);
    localparam logic [CNT_W-1:0] GAP_T  = CNT_W'(GAP_CYC);
    localparam logic [LEN_W-1:0] MAX_T  = LEN_W'(MAX_SYMS);

    logic key_db;

    morse_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_db (
        .CLKin  (CLKin),
        .RSTn   (RSTn),
        .raw    (key_in),
        .stable (key_db)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] press_q, press_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [LEN_W-1:0] sym_cnt_q, sym_cnt_d;
    logic             sym_valid_q, sym_valid_d;
    logic             sym_dash_q, sym_dash_d;
    logic             letter_end_q, letter_end_d;
    logic [LEN_W-1:0] letter_len_q, letter_len_d;
    logic             overflow_q, overflow_d;

    always_comb begin
        state_d      = state_q;
        press_d      = press_q;
        gap_d        = gap_q;
        sym_cnt_d    = sym_cnt_q;
        sym_valid_d  = 1'b0;
        sym_dash_d   = SYM_DOT;
        letter_end_d = 1'b0;
        letter_len_d = '0;
        overflow_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                sym_cnt_d = '0;
                if (key_db) begin
                    press_d = CNT_W'(1);
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (key_db) begin
                    if (press_q != '1) press_d = press_q + 1'b1;
                end else begin
                    if (sym_cnt_q < MAX_T) begin
                        sym_valid_d = 1'b1;
                        sym_dash_d  = (press_q >= DASH_T) ? SYM_DASH : SYM_DOT;
                        sym_cnt_d   = sym_cnt_q + 1'b1;
                    end else begin
                        overflow_d  = 1'b1;
                    end
                    gap_d   = CNT_W'(1);
                    state_d = GAP;
                end
            end
            GAP: begin
                // Timeout wins over a coinciding press; that press then opens
                // the next letter directly so its length is not short by one.
                if (gap_q == GAP_T) begin
                    letter_end_d = 1'b1;
                    letter_len_d = sym_cnt_q;
                    sym_cnt_d    = '0;
                    if (key_db) begin
                        press_d = CNT_W'(1);
                        state_d = PRESS;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (key_db) begin
                    press_d = CNT_W'(1);
                    state_d = PRESS;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= IDLE;
            press_q      <= '0;
            gap_q        <= '0;
            sym_cnt_q    <= '0;
            sym_valid_q  <= 1'b0;
            sym_dash_q   <= 1'b0;
            letter_end_q <= 1'b0;
            letter_len_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            press_q      <= press_d;
            gap_q        <= gap_d;
            sym_cnt_q    <= sym_cnt_d;
            sym_valid_q  <= sym_valid_d;
            sym_dash_q   <= sym_dash_d;
            letter_end_q <= letter_end_d;
            letter_len_q <= letter_len_d;
            overflow_q   <= overflow_d;
        end
    end

    assign sym_valid  = sym_valid_q;
    assign sym_dash   = sym_dash_q;
    assign letter_end = letter_end_q;
    assign letter_len = letter_len_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer: key waveforms are described as level
// runs, a run-level model predicts every strobe and its cycle.
module tb_morse_keyer;

    localparam int D    = 4;
    localparam int DASH = 10;
    localparam int GAP  = 20;
    localparam int W    = 8;
    localparam int LAT  = D + 3;   // key_in change at a negedge to strobe for that edge

    logic       CLKin = 1'b0;
    logic       RSTn  = 1'b1;
    logic       key_in = 1'b0;
    logic       sym_valid, sym_dash, letter_end, overflow;
    logic [2:0] letter_len;

    morse_keyer #(
        .DEBOUNCE_CYC (D),
        .DASH_CYC     (DASH),
        .GAP_CYC      (GAP),
        .CNT_W        (W)
    ) dut (
        .CLKin      (CLKin),
        .RSTn       (RSTn),
        .key_in     (key_in),
        .sym_valid  (sym_valid),
        .sym_dash   (sym_dash),
        .letter_end (letter_end),
        .letter_len (letter_len),
        .overflow   (overflow)
    );

    typedef struct {
        int     kind;   // 0 symbol, 1 overflow, 2 letter end
        bit     dash;
        int     len;
        longint cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     compared   = 0;
    int     mismatched = 0;
    longint cyc        = 0;
    int     seg_lvl[$];
    int     seg_len[$];

    always #5 CLKin = ~CLKin;
    always @(posedge CLKin) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge CLKin) begin
        int   n, kind;
        exp_t e;
        bit   ok;
        n = int'(sym_valid) + int'(overflow) + int'(letter_end);
        if (n > 1) begin
            compared++;
            mismatched++;
            $display("FAIL exclusive: sym=%0b ovf=%0b le=%0b at cyc %0d, required at most one",
                     sym_valid, overflow, letter_end, cyc);
        end else if (n == 1) begin
            compared++;
            kind = sym_valid ? 0 : (overflow ? 1 : 2);
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected: kind=%0d dash=%0b len=%0d at cyc %0d, required none",
                         kind, sym_dash, letter_len, cyc);
            end else begin
                e  = exp_q.pop_front();
                ok = (e.kind == kind) && (e.cyc == cyc) &&
                     (kind != 0 || e.dash == sym_dash) &&
                     (kind != 2 || e.len == int'(letter_len));
                if (!ok) begin
                    mismatched++;
                    $display("FAIL event: got kind=%0d dash=%0b len=%0d cyc=%0d, required kind=%0d dash=%0b len=%0d cyc=%0d",
                             kind, sym_dash, letter_len, cyc, e.kind, e.dash, e.len, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, ".sym_valid"},  int'(sym_valid),  0);
        chk({name, ".sym_dash"},   int'(sym_dash),   0);
        chk({name, ".letter_end"}, int'(letter_end), 0);
        chk({name, ".letter_len"}, int'(letter_len), 0);
        chk({name, ".overflow"},   int'(overflow),   0);
    endtask

    task automatic add(input int lvl, input int len);
        seg_lvl.push_back(lvl);
        seg_len.push_back(len);
    endtask

    // Called on a negedge with the key previously low (or reset just released).
    // Pulses shorter than D inside a run of the other level are invisible; each
    // surviving run shows up D+2 cycles late with its length intact.
    task automatic run_scenario();
        int     rl[$];
        longint rn[$];
        int     cl, cnt;
        longint cn, t, cf, last_fall;
        exp_t   e;
        cl = 0; cn = 0;
        for (int i = 0; i < seg_lvl.size(); i++) begin
            if (seg_lvl[i] == cl || seg_len[i] < D) begin
                cn += seg_len[i];
            end else begin
                rl.push_back(cl); rn.push_back(cn);
                cl = seg_lvl[i]; cn = seg_len[i];
            end
        end
        rl.push_back(cl); rn.push_back(cn + 1000000);
        t = cyc; cnt = 0; last_fall = 0;
        for (int j = 0; j < rl.size(); j++) begin
            if (rl[j] == 1) begin
                cf     = t + rn[j];
                e.kind = (cnt < 4) ? 0 : 1;
                e.dash = (rn[j] >= DASH);
                e.len  = 0;
                e.cyc  = cf + LAT;
                exp_q.push_back(e);
                cnt++;
                last_fall = cf;
            end else if (cnt > 0 && rn[j] >= GAP) begin
                e.kind = 2;
                e.dash = 1'b0;
                e.len  = (cnt > 4) ? 4 : cnt;
                e.cyc  = last_fall + LAT + GAP;
                exp_q.push_back(e);
                cnt = 0;
            end
            t += rn[j];
        end
        for (int i = 0; i < seg_lvl.size(); i++) begin
            key_in = (seg_lvl[i] != 0);
            repeat (seg_len[i]) @(negedge CLKin);
        end
        seg_lvl.delete();
        seg_len.delete();
    endtask

    task automatic rand_scenario();
        int n;
        n = $urandom_range(2, 7);
        for (int p = 0; p < n; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                add(1, $urandom_range(D, 8)); add(0, $urandom_range(1, D - 1)); add(1, $urandom_range(D, 8));
            end else if ($urandom_range(0, 9) == 0) begin
                add(1, $urandom_range(16, 300));
            end else begin
                add(1, $urandom_range(D, 15));
            end
            if (p == n - 1) begin
                add(0, 40);
            end else if ($urandom_range(0, 4) == 0) begin
                add(0, $urandom_range(D, 10)); add(1, $urandom_range(1, D - 1)); add(0, $urandom_range(D, 12));
            end else begin
                add(0, $urandom_range(D, 26));
            end
        end
        run_scenario();
    endtask

    initial begin
        #2 RSTn = 1'b0;
        repeat (3) @(negedge CLKin);
        chk_outputs_zero("reset");
        RSTn = 1'b1;
        repeat (10) @(negedge CLKin);

        // dot, dash boundary, saturation
        add(1, 8);   add(0, 40); run_scenario();
        add(1, 9);   add(0, 40); run_scenario();
        add(1, 10);  add(0, 40); run_scenario();
        add(1, 300); add(0, 40); run_scenario();
        // glitches
        add(1, 3); add(0, 40); run_scenario();
        add(1, 2); add(0, 1); add(1, 3); add(0, 2); add(1, 1); add(0, 40); run_scenario();
        // overflow
        for (int i = 0; i < 4; i++) begin add(1, 8); add(0, 10); end
        add(1, 8); add(0, 40); run_scenario();
        // gap edge
        add(1, 8); add(0, 19); add(1, 8); add(0, 40); run_scenario();
        add(1, 8); add(0, 20); add(1, 8); add(0, 40); run_scenario();
        add(1, 12); add(0, 21); add(1, 11); add(0, 40); run_scenario();

        // reset mid-press, key released during reset
        key_in = 1'b1;
        repeat (12) @(negedge CLKin);
        RSTn = 1'b0;
        #1 chk_outputs_zero("reset_mid");
        key_in = 1'b0;
        repeat (3) @(negedge CLKin);
        chk_outputs_zero("reset_hold");
        RSTn = 1'b1;
        repeat (60) @(negedge CLKin);

        // key held through reset release counts as a fresh press
        key_in = 1'b1;
        repeat (12) @(negedge CLKin);
        RSTn = 1'b0;
        repeat (3) @(negedge CLKin);
        RSTn = 1'b1;
        add(1, 12); add(0, 40); run_scenario();

        for (int s = 0; s < 25; s++) rand_scenario();

        repeat (50) @(negedge CLKin);
        chk("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Upstream front-end of the Morse input path. Takes one raw mechanical key and synchronises and debounces it. Classifies each press by duration as dot or dash, and detects the inter-letter silence. Emits per-symbol strobes plus an end-of-letter strobe with symbol count; these feed the letter-assembly stage that packs symbols into the 4-bit code.

## Interface
Parameters:
- DEBOUNCE_CYC, 1000: consecutive stable cycles required before the debounced key changes.
- DASH_CYC, 3000: press length (cycles) at or above which a symbol is a dash.
- GAP_CYC, 6000: released cycles that terminate a letter.
- CNT_W, 16: width of all internal counters; all three thresholds must be less than 2^CNT_W.

Ports:
- CLKin  in  1  single clock; all logic on its rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- key_in  in  1  raw key, active-high, asynchronous to CLKin.
- sym_valid  out  1  one-cycle strobe: a symbol was accepted.
- sym_dash  out  1  1 = dash, 0 = dot; meaningful only while sym_valid is high.
- letter_end  out  1  one-cycle strobe: letter complete.
- letter_len  out  3  symbols in the completed letter (1..4); meaningful only while letter_end is high.
- overflow  out  1  one-cycle strobe: a 5th-or-later symbol was dropped.

## Operation
- Sync: 2-FF synchroniser on key_in, reset value 0.
- Debounce:
  - key_db (reset 0) toggles once the synchronised value has differed from key_db for DEBOUNCE_CYC consecutive cycles.
  - Any agreeing cycle clears the stability counter.
- FSM, reset state IDLE:
  - IDLE: on key_db=1, set press_cnt←1 and go to PRESS. sym_cnt is 0 in this state.
  - PRESS:
    - While key_db=1: press_cnt increments, saturating at 2^CNT_W−1.
    - On the first cycle with key_db=0, register the symbol with sym_dash = (press_cnt ≥ DASH_CYC).
    - If sym_cnt<4: pulse sym_valid and increment sym_cnt.
    - Otherwise: pulse overflow and discard the symbol; sym_cnt holds at 4.
    - Then go to GAP with gap_cnt←1.
  - GAP:
    - key_db=1: set press_cnt←1 and go to PRESS. The same letter continues.
    - Otherwise gap_cnt increments. On the cycle gap_cnt reaches GAP_CYC: pulse letter_end with letter_len=sym_cnt, clear sym_cnt, go to IDLE.
- letter_end never fires with letter_len=0. IDLE has no timeout.
- sym_valid, overflow and letter_end are mutually exclusive in any cycle.
- Reset mid-operation: immediately clears all counters, state, key_db and all outputs to 0. No strobe is produced for a partial symbol or letter.
- A key held through reset deassertion is seen as a new press after debounce.

## Timing
- Reset value of every output: 0.
- key_in edge to key_db edge: 2 sync cycles + DEBOUNCE_CYC cycles. Rise and fall are symmetric, so press_cnt equals the stable high time of key_in.
- key_db falling (observed) to sym_valid/overflow high: 1 cycle (registered output).
- Last key_db fall to letter_end: GAP_CYC + 1 cycles.
- All strobes are exactly 1 cycle wide.
- Boundaries:
  - press_cnt = DASH_CYC−1 → dot; press_cnt = DASH_CYC → dash.
  - Press starting at gap_cnt = GAP_CYC−1 → same letter; at GAP_CYC → letter_end fires first, and the new press begins a new letter.

## Structure
- Package morse_pkg holds:
  - state enum {IDLE, PRESS, GAP};
  - MAX_SYMS=4;
  - SYM_DOT=0, SYM_DASH=1;
  - LEN_W=3.
- Sub-module morse_debounce (synchroniser + stability counter; ports CLKin, RSTn, raw, stable; parameters DEBOUNCE_CYC, CNT_W).
- The FSM and counters live in the top.

## Test plan
All scenarios use DEBOUNCE_CYC=4, DASH_CYC=10, GAP_CYC=20, CNT_W=8.
- Dot: key_in high 8 cycles, then low 40 cycles → one sym_valid with sym_dash=0; letter_end with letter_len=1 arrives 21 cycles after key_db falls.
- Dash boundary:
  - high 9 → dot;
  - high 10 → dash;
  - high 300 → dash (saturating, no wrap).
- Glitch: 3-cycle high pulse, and separately a bouncing 1-0-1-0 pattern shorter than 4 cycles per level → no strobes, key_db stays 0.
- Overflow: five dots with 10-cycle gaps, then silence → 4×sym_valid, 1×overflow, then letter_end with letter_len=4.
- Gap edge: dot; next press rises so key_db is high at gap_cnt=19 → single letter of 2. The same with gap_cnt=20 → two letters of 1.
- Reset mid-press: RSTn low for 3 cycles during PRESS, key released during reset → all outputs 0, no sym_valid or letter_end afterward.
